// File: rtl/irq_gateway.sv
// Interrupt gateway with claim/complete for the core's machine-external interrupt.
// Sources are synchronised, latched as pending, and claimed/completed over a small bus window.
module irq_gateway #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_SRC-1:0] src,
    input  logic             req,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic             gnt,
    output logic             rvalid,
    output logic [31:0]      rdata,
    output logic             irq_o
);

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_TRIGGER = 2'd3;

    logic [N_SRC-1:0] src_s1, src_s2, src_s3;
    logic [N_SRC-1:0] pending, in_service, enable, trigger;
    logic [N_SRC-1:0] edge_set, level_set, claim_sel, claim_vec, complete_vec;
    logic [3:0]       claim_id;
    logic             rd_acc, wr_acc, claim_acc, complete_acc;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign gnt          = req;
    assign rd_acc       = req & ~we;
    assign wr_acc       = req & we & be[0];
    assign claim_acc    = rd_acc && (addr[3:2] == REG_CLAIM);
    assign complete_acc = wr_acc && (addr[3:2] == REG_CLAIM);
    assign unused_bits  = ^{be[3:1], addr[1:0], wdata};

    // Lowest-numbered enabled pending source has the highest priority.
    always_comb begin
        claim_id  = '0;
        claim_sel = '0;
        for (int n = N_SRC - 1; n >= 0; n--) begin
            if (pending[n] && enable[n]) begin
                claim_id     = 4'(n + 1);
                claim_sel    = '0;
                claim_sel[n] = 1'b1;
            end
        end
    end

    assign claim_vec = claim_acc ? claim_sel : '0;

    always_comb begin
        complete_vec = '0;
        for (int n = 0; n < N_SRC; n++) begin
            complete_vec[n] = complete_acc && (wdata[3:0] == 4'(n + 1));
        end
    end

    // A level source being claimed this cycle must not re-pend on the same edge.
    assign edge_set  = src_s2 & ~src_s3 & trigger;
    assign level_set = src_s2 & ~trigger & ~in_service & ~claim_vec;

    always_comb begin
        rd_mux = '0;
        case (addr[3:2])
            REG_PENDING: rd_mux = 32'(pending);
            REG_ENABLE:  rd_mux = 32'(enable);
            REG_CLAIM:   rd_mux = 32'(claim_id);
            REG_TRIGGER: rd_mux = 32'(trigger);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_s1     <= '0;
            src_s2     <= '0;
            src_s3     <= '0;
            pending    <= '0;
            in_service <= '0;
            enable     <= '0;
            trigger    <= '0;
            irq_o      <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
        end else begin
            src_s1     <= src;
            src_s2     <= src_s1;
            src_s3     <= src_s2;
            pending    <= (pending & ~claim_vec) | edge_set | level_set;
            in_service <= (in_service & ~complete_vec) | claim_vec;
            if (wr_acc && (addr[3:2] == REG_ENABLE)) begin
                enable <= wdata[N_SRC-1:0];
            end
            if (wr_acc && (addr[3:2] == REG_TRIGGER)) begin
                trigger <= wdata[N_SRC-1:0];
            end
            irq_o  <= |(pending & enable);
            rvalid <= req;
            rdata  <= rd_acc ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_irq_gateway.sv
// Scoreboard bench for irq_gateway: directed scenarios plus randomized bus/source traffic
// checked against a set-based model of pending, in-service, enable and trigger state.
module tb_irq_gateway;

    localparam int N_SRC = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [N_SRC-1:0] src = '0;
    logic             req = 1'b0;
    logic             we = 1'b0;
    logic [3:0]       be = '0;
    logic [3:0]       addr = '0;
    logic [31:0]      wdata = '0;
    logic             gnt;
    logic             rvalid;
    logic [31:0]      rdata;
    logic             irq_o;

    irq_gateway #(.N_SRC(N_SRC)) dut (
        .clk(clk), .rstn(rstn), .src(src), .req(req), .we(we), .be(be),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_req = 0;
    int n_rvalid = 0;
    logic [31:0] exp_q[$];

    logic [N_SRC-1:0] m_pend = '0, m_insvc = '0, m_en = '0, m_trig = '0, m_src = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_id(input logic [N_SRC-1:0] v);
        for (int n = 0; n < N_SRC; n++) if (v[n]) return n + 1;
        return 0;
    endfunction

    task automatic model_level();
        m_pend = m_pend | (m_src & ~m_trig & ~m_insvc);
    endtask

    task automatic model_reset();
        m_pend = '0; m_insvc = '0; m_en = '0; m_trig = '0; m_src = '0;
    endtask

    task automatic idle(input int n);
        req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        repeat (n) @(negedge clk);
    endtask

    // One bus request, issued at a negedge and accepted at the following posedge.
    task automatic bus(input logic w, input logic [3:0] b, input logic [1:0] r, input logic [31:0] d);
        logic [31:0] exp;
        int id;
        exp = '0;
        req = 1'b1; we = w; be = b; addr = {r, 2'b00}; wdata = d;
        #1 check("gnt", {31'b0, gnt}, 32'd1);
        if (!w) begin
            case (r)
                2'd0: exp = 32'(m_pend);
                2'd1: exp = 32'(m_en);
                2'd2: begin
                    id = first_id(m_pend & m_en);
                    exp = 32'(id);
                    if (id != 0) begin
                        m_pend[id-1]  = 1'b0;
                        m_insvc[id-1] = 1'b1;
                    end
                end
                default: exp = 32'(m_trig);
            endcase
        end else if (b[0]) begin
            id = int'(d[3:0]);
            case (r)
                2'd1: m_en = d[N_SRC-1:0];
                2'd2: if (id >= 1 && id <= N_SRC) m_insvc[id-1] = 1'b0;
                2'd3: m_trig = d[N_SRC-1:0];
                default: ;
            endcase
            model_level();
        end
        exp_q.push_back(exp);
        n_req++;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic set_src(input logic [N_SRC-1:0] v);
        src = v;
        m_pend = m_pend | (v & ~m_src & m_trig);
        m_src = v;
        model_level();
        idle(5);
    endtask

    task automatic check_irq(input string name);
        check(name, {31'b0, irq_o}, {31'b0, |(m_pend & m_en)});
    endtask

    // Monitor: every rvalid pops one expected response; idle cycles must show rdata=0.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rstn) begin
                if (rvalid) begin
                    n_rvalid++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rvalid_unexpected: got rdata 0x%0h with no request outstanding", rdata);
                    end else begin
                        check("rdata", rdata, exp_q.pop_front());
                    end
                end else begin
                    check("rdata_idle", rdata, 32'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] cid;
        int op;
        repeat (3) @(negedge clk);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_irq", {31'b0, irq_o}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rstn = 1'b1;
        idle(2);
        for (int r = 0; r < 4; r++) bus(1'b0, 4'h1, 2'(r), 32'd0);
        idle(3);

        // Edge path with latency measurement on src[3]
        bus(1'b1, 4'h1, 2'd1, 32'hFF); idle(3);
        bus(1'b1, 4'h1, 2'd3, 32'hFF); idle(3);
        src = 8'h08;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1 check("irq_latency_early", {31'b0, irq_o}, 32'd0);
        @(posedge clk);
        #1 check("irq_latency", {31'b0, irq_o}, 32'd1);
        @(negedge clk);
        src = '0;
        m_pend = m_pend | 8'h08;
        idle(4);
        bus(1'b0, 4'h1, 2'd2, 32'd0);
        check("irq_hold_after_claim", {31'b0, irq_o}, 32'd1);
        @(posedge clk);
        #1 check("irq_drop_after_claim", {31'b0, irq_o}, 32'd0);
        idle(1);
        bus(1'b0, 4'h1, 2'd0, 32'd0); idle(3);
        bus(1'b1, 4'h1, 2'd2, 32'd4); idle(3);

        // Priority: sources 5 and 2 together
        set_src(8'h24); set_src(8'h00);
        bus(1'b0, 4'h1, 2'd2, 32'd0); idle(3); check_irq("irq_after_first_claim");
        bus(1'b0, 4'h1, 2'd2, 32'd0); idle(3); check_irq("irq_after_second_claim");
        bus(1'b0, 4'h1, 2'd2, 32'd0); idle(3);
        bus(1'b1, 4'h1, 2'd2, 32'd3); idle(3);
        bus(1'b1, 4'h1, 2'd2, 32'd6); idle(3);

        // Reset in the middle of a read, with an interrupt outstanding
        set_src(8'h01); set_src(8'h00);
        check("irq_before_reset", {31'b0, irq_o}, 32'd1);
        req = 1'b1; we = 1'b0; be = 4'h1; addr = 4'h4;
        #2 rstn = 1'b0;
        req = 1'b0;
        #1;
        check("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        check("midrst_irq", {31'b0, irq_o}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 check("midrst_rvalid_held", {31'b0, rvalid}, 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        for (int r = 0; r < 4; r++) bus(1'b0, 4'h1, 2'(r), 32'd0);
        idle(3);

        // Level re-pend on src[0], with ignored completes
        bus(1'b1, 4'h1, 2'd1, 32'hFF); idle(3);
        set_src(8'h01);
        bus(1'b0, 4'h1, 2'd2, 32'd0); idle(3);
        bus(1'b0, 4'h1, 2'd0, 32'd0); idle(3);
        bus(1'b1, 4'h1, 2'd2, 32'd0); idle(3);
        bus(1'b1, 4'h1, 2'd2, 32'd12); idle(3);
        bus(1'b0, 4'h1, 2'd0, 32'd0); idle(3);
        check_irq("irq_level_in_service");
        bus(1'b1, 4'h1, 2'd2, 32'd1); idle(1);
        bus(1'b0, 4'h1, 2'd0, 32'd0); idle(3);
        check_irq("irq_level_repend");
        bus(1'b0, 4'h1, 2'd2, 32'd0); idle(3);
        set_src(8'h00);
        bus(1'b1, 4'h1, 2'd2, 32'd1); idle(3);

        // Edge on src[1] in the same cycle as the claim that clears it
        bus(1'b1, 4'h1, 2'd3, 32'hFF); idle(3);
        set_src(8'h02); set_src(8'h00);
        src = 8'h02;
        @(posedge clk); @(posedge clk); @(negedge clk);
        bus(1'b0, 4'h1, 2'd2, 32'd0);
        m_pend[1] = 1'b1;
        m_src = 8'h02;
        idle(3);
        bus(1'b0, 4'h1, 2'd0, 32'd0); idle(3);
        bus(1'b0, 4'h1, 2'd2, 32'd0); idle(3);
        set_src(8'h00);
        bus(1'b1, 4'h1, 2'd2, 32'd2); idle(3);

        // Masking and byte-enable rules
        set_src(8'h10); set_src(8'h00);
        bus(1'b1, 4'h1, 2'd1, 32'h00); idle(3);
        check("mask_irq", {31'b0, irq_o}, 32'd0);
        bus(1'b0, 4'h1, 2'd2, 32'd0); idle(3);
        bus(1'b0, 4'h1, 2'd0, 32'd0); idle(3);
        bus(1'b1, 4'h0, 2'd1, 32'hFF); idle(3);
        bus(1'b0, 4'h1, 2'd1, 32'd0); idle(3);
        bus(1'b1, 4'h1, 2'd1, 32'hFF); idle(3);
        check_irq("unmask_irq");

        // Back-to-back reads
        bus(1'b0, 4'h1, 2'd0, 32'd0);
        bus(1'b0, 4'h1, 2'd2, 32'd0);
        bus(1'b0, 4'h1, 2'd1, 32'd0);
        bus(1'b0, 4'h1, 2'd3, 32'd0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0: set_src(N_SRC'($urandom));
                1: bus(1'b1, 4'h1, 2'd1, $urandom);
                2: bus(1'b1, 4'h1, 2'd3, $urandom);
                3, 4: bus(1'b0, 4'h1, 2'd2, 32'd0);
                5: begin
                    cid = 4'($urandom_range(0, 15));
                    if (m_insvc != '0 && $urandom_range(0, 1) == 1) begin
                        for (int n = 0; n < N_SRC; n++)
                            if (m_insvc[n] && $urandom_range(0, 1) == 1) cid = 4'(n + 1);
                    end
                    bus(1'b1, 4'h1, 2'd2, {$urandom_range(0, 255) << 4, cid});
                end
                6: bus(1'b0, 4'h1, 2'($urandom_range(0, 3)), 32'd0);
                7: bus(1'b1, {3'($urandom), 1'b0}, 2'($urandom_range(0, 3)), $urandom);
                8: begin
                    for (int k = 0; k < int'($urandom_range(2, 5)); k++)
                        bus(1'b0, 4'h1, 2'($urandom_range(0, 3)), 32'd0);
                end
                default: bus(1'b1, 4'h1, 2'd0, $urandom);
            endcase
            idle(3);
            check_irq("rand_irq");
        end

        idle(5);
        check("rvalid_count", 32'(n_rvalid), 32'(n_req));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
